// File: rtl/deser_frame_arbiter.sv
// Frame-granular round-robin arbiter in front of a shared Deserializer.
//
// A channel that wins arbitration owns the Deserializer input until exactly
// N_SAMPLES samples have been accepted. All inputs are then held off until the
// assembled frame is consumed downstream (frame_fire), and the frame is tagged
// with its source channel on out_chan.
//
// Ports:
//   clk, reset   - clock, synchronous active-high reset
//   recv_val/rdy - per-channel sample handshake (upstream front ends)
//   recv_msg     - per-channel sample payload (unpacked array)
//   deser_val    - to Deserializer recv_val
//   deser_rdy    - from Deserializer recv_rdy
//   deser_msg    - to Deserializer recv_msg
//   frame_fire   - Deserializer send_val && send_rdy
//   chan_val     - out_chan identifies the current frame owner
//   out_chan     - owner of the frame being built or drained
//   frame_count  - completed frames, wraps at 2^16
module deser_frame_arbiter #(
    parameter int unsigned N_CHANNELS = 4,
    parameter int unsigned N_SAMPLES  = 8,
    parameter int unsigned BIT_WIDTH  = 32,
    localparam int unsigned CHAN_W    = (N_CHANNELS > 1) ? $clog2(N_CHANNELS) : 1,
    localparam int unsigned CNT_W     = $clog2(N_SAMPLES + 1)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [N_CHANNELS-1:0] recv_val,
    output logic [N_CHANNELS-1:0] recv_rdy,
    input  logic [BIT_WIDTH-1:0] recv_msg [N_CHANNELS],
    output logic                 deser_val,
    input  logic                 deser_rdy,
    output logic [BIT_WIDTH-1:0] deser_msg,
    input  logic                 frame_fire,
    output logic                 chan_val,
    output logic [CHAN_W-1:0]    out_chan,
    output logic [15:0]          frame_count
);

    typedef enum logic [1:0] {StIdle, StStream, StDrain} state_e;

    state_e            state_q, state_d;
    logic [CHAN_W-1:0] grant_q, grant_d;
    logic [CHAN_W-1:0] ptr_q, ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [15:0]       frame_count_q, frame_count_d;

    logic [CHAN_W-1:0] winner;
    logic              win_found;
    logic [CHAN_W-1:0] cand;
    int unsigned       idx;
    logic              fire;

    // Round-robin search starting at ptr; the first requester found wins.
    always_comb begin
        winner    = '0;
        win_found = 1'b0;
        idx       = 0;
        cand      = '0;
        for (int unsigned i = 0; i < N_CHANNELS; i++) begin
            idx  = (32'(ptr_q) + i) % N_CHANNELS;
            cand = CHAN_W'(idx);
            if (!win_found && recv_val[cand]) begin
                winner    = cand;
                win_found = 1'b1;
            end
        end
    end

    // Sample accepted by the Deserializer; only meaningful while streaming.
    assign fire = (state_q == StStream) && recv_val[grant_q] && deser_rdy;

    always_comb begin
        state_d       = state_q;
        grant_d       = grant_q;
        ptr_d         = ptr_q;
        count_d       = count_q;
        frame_count_d = frame_count_q;
        recv_rdy      = '0;
        deser_val     = 1'b0;
        deser_msg     = '0;
        chan_val      = 1'b0;
        out_chan      = '0;

        unique case (state_q)
            StIdle: begin
                if (win_found) begin
                    grant_d = winner;
                    count_d = '0;
                    state_d = StStream;
                end
            end
            StStream: begin
                deser_val          = recv_val[grant_q];
                deser_msg          = recv_msg[grant_q];
                // Ready depends only on deser_rdy, never on recv_val.
                recv_rdy[grant_q]  = deser_rdy;
                chan_val           = 1'b1;
                out_chan           = grant_q;
                if (fire) begin
                    if (count_q == CNT_W'(N_SAMPLES - 1)) begin
                        count_d = '0;
                        state_d = StDrain;
                    end else begin
                        count_d = count_q + 1'b1;
                    end
                end
            end
            StDrain: begin
                chan_val = 1'b1;
                out_chan = grant_q;
                if (frame_fire) begin
                    ptr_d         = (grant_q == CHAN_W'(N_CHANNELS - 1)) ? '0 : grant_q + 1'b1;
                    frame_count_d = frame_count_q + 16'd1;
                    state_d       = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= StIdle;
            grant_q       <= '0;
            ptr_q         <= '0;
            count_q       <= '0;
            frame_count_q <= '0;
        end else begin
            state_q       <= state_d;
            grant_q       <= grant_d;
            ptr_q         <= ptr_d;
            count_q       <= count_d;
            frame_count_q <= frame_count_d;
        end
    end

    assign frame_count = frame_count_q;

endmodule

// File: tb/tb_deser_frame_arbiter.sv
// Directed bench for deser_frame_arbiter (4 channels, 8 samples per frame).
// Each channel source emits base[c] + n for its n-th accepted sample.
module tb_deser_frame_arbiter;

    localparam int unsigned NC = 4;
    localparam int unsigned NS = 8;
    localparam int unsigned BW = 32;

    logic          clk;
    logic          reset;
    logic [NC-1:0] recv_val;
    logic [NC-1:0] recv_rdy;
    logic [BW-1:0] recv_msg [NC];
    logic          deser_val;
    logic          deser_rdy;
    logic [BW-1:0] deser_msg;
    logic          frame_fire;
    logic          chan_val;
    logic [1:0]    out_chan;
    logic [15:0]   frame_count;

    int            n_checks = 0;
    int            n_errors = 0;
    logic [31:0]   base [NC];
    int            sent [NC];
    logic [31:0]   got_q [$];
    int            exp_fc = 0;

    deser_frame_arbiter #(
        .N_CHANNELS(NC),
        .N_SAMPLES (NS),
        .BIT_WIDTH (BW)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .recv_val   (recv_val),
        .recv_rdy   (recv_rdy),
        .recv_msg   (recv_msg),
        .deser_val  (deser_val),
        .deser_rdy  (deser_rdy),
        .deser_msg  (deser_msg),
        .frame_fire (frame_fire),
        .chan_val   (chan_val),
        .out_chan   (out_chan),
        .frame_count(frame_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // One clock: capture handshakes before the edge, advance sources after it.
    task automatic step();
        logic [NC-1:0] fired;
        #1;
        fired = recv_val & recv_rdy;
        if (deser_val && deser_rdy && !reset) got_q.push_back(deser_msg);
        @(posedge clk);
        #1;
        for (int c = 0; c < NC; c++) begin
            if (fired[c] && !reset) begin
                sent[c]++;
                recv_msg[c] = base[c] + 32'(sent[c]);
            end
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_recv_rdy"}, 32'(recv_rdy), 0);
        check({tag, "_deser_val"}, 32'(deser_val), 0);
        check({tag, "_deser_msg"}, deser_msg, 0);
        check({tag, "_chan_val"}, 32'(chan_val), 0);
        check({tag, "_out_chan"}, 32'(out_chan), 0);
        check({tag, "_frame_count"}, 32'(frame_count), 0);
    endtask

    // Full frame from IDLE: arbitration, NS samples, drain with 'stall' cycles
    // before frame_fire. bp adds ready toggling, a 5-cycle valid gap and stray
    // frame_fire pulses while streaming.
    task automatic do_frame(input int ch, input bit bp, input int stall);
        int start;
        int budget;
        int drop_left;
        bit dropped;
        bit ok;
        got_q.delete();
        start = sent[ch];
        #1;
        check("idle_recv_rdy", 32'(recv_rdy), 0);
        check("idle_chan_val", 32'(chan_val), 0);
        step();
        #1;
        check("grant", 32'(out_chan), 32'(ch));
        check("stream_chan_val", 32'(chan_val), 1);
        ok = 1'b1;
        budget = 0;
        dropped = 1'b0;
        drop_left = 0;
        while (got_q.size() < NS && budget < 200) begin
            if (bp) begin
                deser_rdy  = (budget % 2 == 1);
                frame_fire = (budget % 3 == 1);
                if (!dropped && got_q.size() == 3) begin
                    dropped = 1'b1;
                    drop_left = 5;
                end
                if (drop_left > 0) begin
                    recv_val[ch] = 1'b0;
                    drop_left--;
                end else begin
                    recv_val[ch] = 1'b1;
                end
            end
            #1;
            if (out_chan !== 2'(ch) || chan_val !== 1'b1) ok = 1'b0;
            if (recv_rdy !== (deser_rdy ? 4'(1 << ch) : 4'b0)) ok = 1'b0;
            if (deser_val !== recv_val[ch]) ok = 1'b0;
            if (deser_val && deser_msg !== recv_msg[ch]) ok = 1'b0;
            step();
            budget++;
        end
        deser_rdy  = 1'b1;
        frame_fire = 1'b0;
        recv_val[ch] = recv_val[ch] | bp;
        check("stream_ok", 32'(ok), 1);
        check("n_samples", 32'(got_q.size()), NS);
        if (!bp) check("consecutive", 32'(budget), NS);
        for (int i = 0; i < NS; i++) begin
            if (i < got_q.size()) check("msg", got_q[i], base[ch] + 32'(start + i));
        end
        ok = 1'b1;
        for (int s = 0; s < stall; s++) begin
            #1;
            if (recv_rdy !== 4'b0 || deser_val !== 1'b0) ok = 1'b0;
            if (chan_val !== 1'b1 || out_chan !== 2'(ch)) ok = 1'b0;
            if (frame_count !== 16'(exp_fc)) ok = 1'b0;
            step();
        end
        check("drain_ok", 32'(ok), 1);
        frame_fire = 1'b1;
        step();
        frame_fire = 1'b0;
        exp_fc++;
        #1;
        check("frame_count", 32'(frame_count), 32'(exp_fc));
        check("after_drain_chan_val", 32'(chan_val), 0);
    endtask

    initial begin
        base[0] = 32'hA000;
        base[1] = 32'hB000;
        base[2] = 32'h0010;
        base[3] = 32'hD000;
        for (int c = 0; c < NC; c++) begin
            sent[c] = 0;
            recv_msg[c] = base[c];
        end
        reset = 1'b1;
        recv_val = '0;
        deser_rdy = 1'b0;
        frame_fire = 1'b0;
        step();
        step();
        check_reset_outputs("reset");
        reset = 1'b0;
        step();

        // Single requester ch2: 0x10..0x17, then ptr=3.
        recv_val = 4'b0100;
        deser_rdy = 1'b1;
        do_frame(2, 1'b0, 1);

        // Pointer wrap: ch3 wins from ptr=3, then 0, then 3.
        recv_val = 4'b1001;
        do_frame(3, 1'b0, 1);
        do_frame(0, 1'b0, 1);
        do_frame(3, 1'b0, 1);

        // Round-robin with all channels requesting.
        recv_val = 4'b1111;
        do_frame(0, 1'b0, 1);
        do_frame(1, 1'b0, 1);
        do_frame(2, 1'b0, 1);
        do_frame(3, 1'b0, 1);
        do_frame(0, 1'b0, 1);

        // Backpressure and valid gap on ch1, followed by a 20-cycle drain stall.
        do_frame(1, 1'b1, 20);

        // Reset after 5 samples of a ch2 frame.
        step();
        #1;
        check("rst_grant", 32'(out_chan), 2);
        for (int i = 0; i < 5; i++) step();
        #1;
        check("rst_chan_val_pre", 32'(chan_val), 1);
        recv_val = '0;
        reset = 1'b1;
        step();
        check_reset_outputs("midreset");
        reset = 1'b0;
        exp_fc = 0;
        recv_val = 4'b1111;
        do_frame(0, 1'b0, 1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/deser_frame_arbiter.md
Name: deser_frame_arbiter

Overview:
- Shares one Deserializer among N_CHANNELS val/rdy sample streams.
- Arbitration is frame-granular round-robin: a granted channel keeps the deserializer input until exactly N_SAMPLES samples are accepted.
- The arbiter then holds all inputs off until the assembled frame is consumed downstream, and tags the frame with its source channel.
- Sits between the per-channel front ends and the Deserializer's recv interface; it also observes the Deserializer's send handshake.

Parameters:
- N_CHANNELS, 4, number of requesting streams (>= 2).
- N_SAMPLES, 8, samples per frame; must equal the Deserializer's N_SAMPLES.
- BIT_WIDTH, 32, sample width.

Ports:
- clk  input  1  clock
- reset  input  1  synchronous, active-high reset
- recv_val  input  N_CHANNELS  per-channel sample valid
- recv_rdy  output  N_CHANNELS  per-channel ready
- recv_msg  input  BIT_WIDTH x N_CHANNELS (unpacked)  per-channel sample
- deser_val  output  1  to Deserializer recv_val
- deser_rdy  input  1  from Deserializer recv_rdy
- deser_msg  output  BIT_WIDTH  to Deserializer recv_msg
- frame_fire  input  1  Deserializer send_val && send_rdy
- chan_val  output  1  high while out_chan identifies the current frame owner
- out_chan  output  max(1,$clog2(N_CHANNELS))  owner of the frame being built or drained
- frame_count  output  16  total frames completed, wraps at 2^16

Behaviour:
- Reset values: state=IDLE, grant=0, ptr=0, count=0, frame_count=0.
- Reset outputs: recv_rdy=0, deser_val=0, deser_msg=0, chan_val=0, out_chan=0.
- Reset asserted mid-frame aborts the frame with no partial output. The Deserializer is reset by the same signal.

State IDLE:
- All recv_rdy=0, deser_val=0, chan_val=0.
- Winner = first channel with recv_val=1, searching ptr, ptr+1, ... mod N_CHANNELS.
- If a winner exists: grant<=winner, count<=0, next STREAM. Otherwise stay IDLE.
- Arbitration costs exactly 1 cycle; no sample is accepted in IDLE.

State STREAM:
- deser_val=recv_val[grant], deser_msg=recv_msg[grant].
- recv_rdy[grant]=deser_rdy; every other recv_rdy=0.
- chan_val=1, out_chan=grant.
- Fire = deser_val && deser_rdy; count increments on fire.
- Fire with count==N_SAMPLES-1: count<=0, next DRAIN.
- recv_val[grant] dropping mid-frame causes no switch; the grant is held indefinitely.
- Other channels' recv_val are ignored until the next IDLE.

State DRAIN:
- All recv_rdy=0, deser_val=0, chan_val=1, out_chan=grant.
- On frame_fire: ptr<=(grant+1) mod N_CHANNELS (N_CHANNELS-1 wraps to 0), frame_count<=frame_count+1, next IDLE.
- frame_fire is ignored in IDLE and STREAM.

Invariants and timing:
- Count width: $clog2(N_SAMPLES+1) bits, so it never overflows before the compare.
- At most one recv_rdy bit is high in any cycle.
- recv_rdy is combinational from deser_rdy only; there is no comb path from recv_val to recv_rdy.
- Minimum frame period = 1 (IDLE) + N_SAMPLES + DRAIN cycles (>= 1).

Test Plan:
- Single requester: N_CHANNELS=4, N_SAMPLES=8; only ch2 streams 0x10..0x17 with deser_rdy=1. Required: IDLE 1 cycle, then 8 consecutive fires forwarded in order; DRAIN with out_chan=2; after frame_fire, frame_count=1 and ptr=3.
- Round-robin fairness: all four channels continuously valid, frame_fire 1 cycle after each DRAIN entry. Required: grants 0,1,2,3,0 in that order, each a full 8-sample frame with no interleaving of messages between channels.
- Pointer wrap: ch3 wins, then only ch0 and ch3 request. Required: next grant=0 (ptr wrapped to 0), then 3.
- Backpressure and gaps: during a ch1 frame, deser_rdy toggles and recv_val[1] drops for 5 cycles. Required: count advances only on fires, no grant change, and exactly 8 samples are delivered.
- Downstream stall: frame_fire held low 20 cycles in DRAIN. Required: every recv_rdy=0 and deser_val=0 throughout; frame_count unchanged until frame_fire.
- Reset mid-frame: reset asserted after 5 samples of a ch2 frame. Required: next cycle all outputs at reset values, ptr=0, frame_count unchanged from 0/reset; the following frame starts at count 0 from ch0 if it is requesting.
